cylon_scanner: RTL and testbench
================================

// Module: cylon_scanner
// PURPOSE
//  Parametrised Cylon/Larson scanner for a WS2812-style strip: a coloured head sweeps NUM_LEDS pixels with a decaying tail.
//  Adds run-time colour, bounce/wrap mode, a pass count and a fade-out, with explicit Busy/Done handshake.
//  Sits between the control FSM (Go) and the serial LED driver (GRBSeq, Cycle).
// PARAMETERS
//  NUM_LEDS     5         pixels in strip (>=1)
//  TICK_DIV     33554433  clk cycles per animation step (>=2)
//  TAIL_LEN     3         lit pixels incl. head (1..NUM_LEDS)
//  DECAY_SHIFT  2         per-byte right shift per tail position
// PORTS
//  clk     in   1             system clock, all logic on posedge
//  reset   in   1             synchronous, active-high
//  Go      in   1             start request; sampled only in IDLE
//  Mode    in   1             0 = bounce, 1 = wrap; latched on Go
//  Color   in   24            head colour {G,R,B}; latched on Go
//  Passes  in   4             sweeps to run; 0 = run until Go low; latched on Go
//  GRBSeq  out  24*NUM_LEDS   registered frame; LED0 = bits [24*NUM_LEDS-1 -: 24]
//  Cycle   out  1             1-clk pulse on each step tick
//  Busy    out  1             high in SWEEP and FADE
//  Done    out  1             1-clk pulse on the step that returns to IDLE
// BEHAVIOUR
//  Reset: state IDLE, GRBSeq=0, Cycle=0, Busy=0, Done=0, tick=0, history cleared. Reset mid-run aborts at once.
//  Tick counter: held at 0 in IDLE; else counts 0..TICK_DIV-1 and wraps. Cycle=1 when tick==TICK_DIV-1.
//  IDLE: Go=1 latches Mode/Color/Passes, head=0, dir=up, pass_cnt=0, history={0}. Next cycle: SWEEP, Busy=1,
//    GRBSeq shows head on LED0. Go while Busy is ignored.
//  History: TAIL_LEN entries {valid,pos}; entry 0 = head. Each step shifts in the new head (or invalid in FADE).
//  Render (registered, 1 clk after history update): LED i = Color with each byte >> (k*DECAY_SHIFT),
//    where k is the smallest valid entry with pos==i; no match -> 0. A shift >=8 gives 0.
//  SWEEP step: an endpoint is head==NUM_LEDS-1 going up or head==0 going down.
//    Not at an endpoint: head += dir.
//    At an endpoint: pass_cnt++. If Passes!=0 and pass_cnt+1==Passes -> FADE, head not moved.
//      If Passes==0 and Go==0 -> FADE. Otherwise bounce: flip dir and step once (no repeated endpoint);
//      wrap: head=0, dir stays up.
//    NUM_LEDS==1: every step is an endpoint; head stays 0.
//  FADE: each step shifts in an invalid entry. After TAIL_LEN steps all entries are invalid (GRBSeq=0):
//    IDLE, Busy=0, Done=1 for one clk.
//  Go held high at that Done step restarts on the next clk.
//  pass_cnt is 4 bits; it saturates only in Passes==0 runs (no wrap side effects).
// STRUCTURE
//  Shared package cylon_pkg: GRB_W=24, state encodings IDLE/SWEEP/FADE, dim_grb(color,shift) function.
//  Sub-module cylon_tick_div (TICK_DIV): enable, reset -> tick pulse. Remainder: FSM, history, render.
// TESTING  (NUM_LEDS=5, TICK_DIV=4, TAIL_LEN=3, DECAY_SHIFT=2)
//  1. Assert reset for 2 clk -> GRBSeq=0, Busy=0, Cycle never pulses while IDLE.
//  2. Go=1 for 1 clk, Color=0000FF, Mode=0, Passes=2 -> LED heads 0,1,2,3,4,3,2,1,0. After head=1:
//     LED1=0000FF, LED0=00003F. Then 3 fade steps, Done once, total 12 Cycle pulses.
//  3. Mode=1, Passes=1, Color=FF0000 -> heads 0..4, then fade. First fade frame: LED4=3F0000, LED3=0F0000.
//     Done after 3 fade steps.
//  4. Passes=0, Go held high 30 clk then low -> continuous sweep. FADE starts only at the next endpoint step.
//  5. Go pulsed mid-SWEEP with new Color -> ignored, colour unchanged. reset mid-SWEEP -> next clk GRBSeq=0, Busy=0.
//  6. NUM_LEDS=1, TAIL_LEN=1, Passes=3 -> LED0=Color for 3 steps, 1 fade step, Done.

Source files
------------

// File: rtl/cylon_pkg.sv
// Shared types and helpers for the Cylon/Larson LED scanner.
package cylon_pkg;

  localparam int GRB_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FADE  = 2'd2
  } state_t;

  // Dims each colour byte independently; shifts of 8 or more give black.
  function automatic logic [GRB_W-1:0] dim_grb(input logic [GRB_W-1:0] color, input int shift);
    logic [GRB_W-1:0] res;
    res = '0;
    if (shift < 8) begin
      for (int b = 0; b < 3; b++) begin
        res[b*8 +: 8] = color[b*8 +: 8] >> shift;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cylon_tick_div.sv
// Animation step divider: counts while enabled and pulses once every TICK_DIV clocks.
module cylon_tick_div #(
  parameter int TICK_DIV = 33554433
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/cylon_scanner.sv
// Cylon/Larson scanner: a coloured head sweeps the strip leaving a decaying tail,
// with bounce/wrap modes, a pass count, a fade-out and a Busy/Done handshake.
module cylon_scanner
  import cylon_pkg::*;
#(
  parameter int NUM_LEDS    = 5,
  parameter int TICK_DIV    = 33554433,
  parameter int TAIL_LEN    = 3,
  parameter int DECAY_SHIFT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Go,
  input  logic                      Mode,
  input  logic [GRB_W-1:0]          Color,
  input  logic [3:0]                Passes,
  output logic [GRB_W*NUM_LEDS-1:0] GRBSeq,
  output logic                      Cycle,
  output logic                      Busy,
  output logic                      Done
);

  localparam int            PW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int            FW       = GRB_W * NUM_LEDS;
  localparam logic [PW-1:0] LAST_POS = PW'(NUM_LEDS - 1);

  state_t                       state, state_nxt;
  logic [PW-1:0]                head, head_nxt;
  logic                         dir_up, dir_up_nxt;
  logic [3:0]                   pass_cnt, pass_cnt_nxt;
  logic                         mode_q, mode_nxt;
  logic [GRB_W-1:0]             color_q, color_nxt;
  logic [3:0]                   passes_q, passes_nxt;
  logic [TAIL_LEN-1:0]          hist_valid, hist_valid_nxt;
  logic [TAIL_LEN-1:0][PW-1:0]  hist_pos, hist_pos_nxt;
  logic                         done_nxt;
  logic                         at_end, finish_pass, shift_en, shift_valid;
  logic [FW-1:0]                frame_nxt;

  cylon_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .enable (Busy),
    .tick   (Cycle)
  );

  assign Busy = (state != IDLE);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt      = state;
    head_nxt       = head;
    dir_up_nxt     = dir_up;
    pass_cnt_nxt   = pass_cnt;
    mode_nxt       = mode_q;
    color_nxt      = color_q;
    passes_nxt     = passes_q;
    hist_valid_nxt = hist_valid;
    hist_pos_nxt   = hist_pos;
    done_nxt       = 1'b0;
    shift_en       = 1'b0;
    shift_valid    = 1'b0;
    at_end         = dir_up ? (head == LAST_POS) : (head == '0);
    finish_pass    = (passes_q != 4'd0) ? (pass_cnt + 4'd1 == passes_q) : !Go;

    case (state)
      IDLE: begin
        if (Go) begin
          mode_nxt       = Mode;
          color_nxt      = Color;
          passes_nxt     = Passes;
          head_nxt       = '0;
          dir_up_nxt     = 1'b1;
          pass_cnt_nxt   = '0;
          hist_valid_nxt = '0;
          hist_valid_nxt[0] = 1'b1;
          hist_pos_nxt   = '0;
          state_nxt      = SWEEP;
        end
      end
      SWEEP: begin
        if (Cycle) begin
          shift_en    = 1'b1;
          shift_valid = 1'b1;
          if (!at_end) begin
            head_nxt = dir_up ? head + PW'(1) : head - PW'(1);
          end else begin
            pass_cnt_nxt = (pass_cnt == 4'hF) ? pass_cnt : pass_cnt + 4'd1;
            if (finish_pass) begin
              // The final endpoint keeps the frame; the fade starts on the next step.
              state_nxt = FADE;
              shift_en  = 1'b0;
            end else if (mode_q) begin
              head_nxt = '0;
            end else begin
              dir_up_nxt = !dir_up;
              if (NUM_LEDS > 1) begin
                head_nxt = dir_up ? head - PW'(1) : head + PW'(1);
              end
            end
          end
        end
      end
      FADE: begin
        if (Cycle) begin
          shift_en = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (shift_en) begin
      for (int k = TAIL_LEN - 1; k > 0; k--) begin
        hist_valid_nxt[k] = hist_valid[k-1];
        hist_pos_nxt[k]   = hist_pos[k-1];
      end
      hist_valid_nxt[0] = shift_valid;
      hist_pos_nxt[0]   = head_nxt;
    end

    if (state == FADE && Cycle && hist_valid_nxt == '0) begin
      state_nxt = IDLE;
      done_nxt  = 1'b1;
    end
  end

  // Scanning from the oldest entry down lets the freshest match win.
  always_comb begin
    frame_nxt = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      for (int k = TAIL_LEN - 1; k >= 0; k--) begin
        if (hist_valid[k] && hist_pos[k] == PW'(i)) begin
          frame_nxt[FW-1-GRB_W*i -: GRB_W] = dim_grb(color_q, k * DECAY_SHIFT);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the history is only TAIL_LEN entries, so it is reset like any other register.
      state      <= IDLE;
      head       <= '0;
      dir_up     <= 1'b1;
      pass_cnt   <= '0;
      mode_q     <= 1'b0;
      color_q    <= '0;
      passes_q   <= '0;
      hist_valid <= '0;
      hist_pos   <= '0;
      GRBSeq     <= '0;
      Done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      head       <= head_nxt;
      dir_up     <= dir_up_nxt;
      pass_cnt   <= pass_cnt_nxt;
      mode_q     <= mode_nxt;
      color_q    <= color_nxt;
      passes_q   <= passes_nxt;
      hist_valid <= hist_valid_nxt;
      hist_pos   <= hist_pos_nxt;
      GRBSeq     <= frame_nxt;
      Done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_cylon_scanner.sv
// Self-checking bench: a queue-based behavioural scanner model checked every cycle,
// plus literal expectations for the documented scenarios and a single-pixel instance.
module tb_cylon_scanner;

  localparam int N  = 5;
  localparam int T  = 4;
  localparam int L  = 3;
  localparam int D  = 2;
  localparam int FW = 24 * N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0, mode = 1'b0;
  logic [23:0]   color = '0;
  logic [3:0]    passes = '0;
  logic [FW-1:0] grb;
  logic          cycle, busy, done;

  logic          go_b = 1'b0, mode_b = 1'b0;
  logic [23:0]   color_b = '0;
  logic [3:0]    passes_b = 4'd3;
  logic [23:0]   grb_b;
  logic          cycle_b, busy_b, done_b;

  int n_cmp = 0, n_bad = 0;
  int cyc_cnt = 0, done_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cylon_scanner #(.NUM_LEDS(N), .TICK_DIV(T), .TAIL_LEN(L), .DECAY_SHIFT(D)) dut (
    .clk(clk), .reset(reset), .Go(go), .Mode(mode), .Color(color), .Passes(passes),
    .GRBSeq(grb), .Cycle(cycle), .Busy(busy), .Done(done)
  );

  cylon_scanner #(.NUM_LEDS(1), .TICK_DIV(T), .TAIL_LEN(1), .DECAY_SHIFT(D)) dut_b (
    .clk(clk), .reset(reset), .Go(go_b), .Mode(mode_b), .Color(color_b), .Passes(passes_b),
    .GRBSeq(grb_b), .Cycle(cycle_b), .Busy(busy_b), .Done(done_b)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy = 1'b0, m_fading = 1'b0, m_up = 1'b1, m_wrap = 1'b0, m_done = 1'b0, m_step;
  int          m_phase = 0, m_head = 0, m_sweeps = 0, m_passes = 0, m_fade_left = 0;
  logic [23:0] m_col = '0;
  int          m_trail[$];
  logic [FW-1:0] m_grb = '0;

  function automatic logic [23:0] bdim(logic [23:0] c, int s);
    logic [23:0] r = '0;
    if (s < 8) begin
      for (int b = 0; b < 3; b++) r[8*b +: 8] = 8'(int'(c[8*b +: 8]) / (1 << s));
    end
    return r;
  endfunction

  function automatic logic [FW-1:0] model_frame();
    logic [FW-1:0] f = '0;
    for (int i = 0; i < N; i++)
      for (int k = L - 1; k >= 0; k--)
        if (m_trail[k] == i) f[FW-1-24*i -: 24] = bdim(m_col, k * D);
    return f;
  endfunction

  task automatic push_pos(input int p);
    m_trail.push_front(p);
    void'(m_trail.pop_back());
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_fading = 0; m_phase = 0; m_done = 0; m_grb = '0;
      m_trail.delete();
      repeat (L) m_trail.push_back(-1);
    end else begin
      m_grb  = model_frame();
      m_done = 0;
      if (!m_busy) begin
        if (go) begin
          m_busy = 1; m_fading = 0; m_phase = 0; m_head = 0; m_up = 1; m_sweeps = 0;
          m_wrap = mode; m_col = color; m_passes = int'(passes);
          m_trail.delete();
          m_trail.push_back(0);
          repeat (L - 1) m_trail.push_back(-1);
        end
      end else begin
        m_step = (m_phase % T) == T - 1;
        m_phase++;
        if (m_step && m_fading) begin
          push_pos(-1);
          m_fade_left--;
          if (m_fade_left == 0) begin m_busy = 0; m_done = 1; end
        end else if (m_step) begin
          if (!(m_up ? m_head == N - 1 : m_head == 0)) begin
            m_head += m_up ? 1 : -1;
            push_pos(m_head);
          end else begin
            m_sweeps++;
            if ((m_passes != 0 && m_sweeps == m_passes) || (m_passes == 0 && !go)) begin
              m_fading = 1; m_fade_left = L;
            end else if (m_wrap) begin
              m_head = 0;
              push_pos(m_head);
            end else begin
              m_up = !m_up;
              if (N > 1) m_head += m_up ? 1 : -1;
              push_pos(m_head);
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("grbseq", 128'(grb), 128'(m_grb));
      check("busy",   128'(busy), 128'(m_busy));
      check("cycle",  128'(cycle), 128'(m_busy && ((m_phase % T) == T - 1)));
      check("done",   128'(done), 128'(m_done));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step_clk();
    @(negedge clk);
    if (cycle) cyc_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic start_run(input bit m, input logic [23:0] c, input logic [3:0] p, input bit hold);
    @(negedge clk);
    mode = m; color = c; passes = p; go = 1'b1;
    cyc_cnt = 0; done_cnt = 0;
    step_clk();
    if (!hold) go = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit rnd);
    bit hit = 0;
    for (int c = 0; c < budget && !hit; c++) begin
      if (rnd) go = 1'($urandom_range(0, 1));
      step_clk();
      if (done_cnt > 0) hit = 1;
    end
    if (rnd) go = 1'b0;
    check(name, 128'(hit), 128'(1));
  endtask

  task automatic wait_led(input string name, input int led, input logic [23:0] val, input int budget);
    bit hit = 0;
    for (int c = 0; c < budget && !hit; c++) begin
      step_clk();
      if (grb[FW-1-24*led -: 24] == val) hit = 1;
    end
    check(name, 128'(hit), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] acc;
    int cb, db;
    bit hit;

    // Reset and idle
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_grb",  128'(grb), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_grb_b", 128'(grb_b), 128'(0));
    reset = 1'b0;
    cyc_cnt = 0;
    repeat (10) step_clk();
    check("idle_cycles", 128'(cyc_cnt), 128'(0));

    // Bounce, two passes, blue
    start_run(1'b0, 24'h0000FF, 4'd2, 1'b0);
    wait_led("bounce_head1_seen", 1, 24'h0000FF, 50);
    check("bounce_head1_frame", 128'(grb), 128'(120'h00003F_0000FF_000000_000000_000000));
    wait_done("bounce_done", 200, 1'b0);
    check("bounce_cycles", 128'(cyc_cnt), 128'(12));
    repeat (3) step_clk();
    check("bounce_done_once", 128'(done_cnt), 128'(1));
    check("bounce_dark", 128'(grb), 128'(0));

    // Wrap, one pass, green
    start_run(1'b1, 24'hFF0000, 4'd1, 1'b0);
    wait_led("wrap_fade_seen", 4, 24'h3F0000, 80);
    check("wrap_fade_frame", 128'(grb), 128'(120'h000000_000000_000000_0F0000_3F0000));
    wait_done("wrap_done", 100, 1'b0);
    check("wrap_cycles", 128'(cyc_cnt), 128'(8));

    // Continuous run while Go is held
    start_run(1'b0, 24'($urandom), 4'd0, 1'b1);
    repeat (29) step_clk();
    check("cont_busy", 128'(busy), 128'(1));
    go = 1'b0;
    wait_done("cont_done", 400, 1'b0);

    // Go held across Done restarts immediately
    start_run(1'b1, 24'h123456, 4'd1, 1'b1);
    wait_done("hold_done", 100, 1'b0);
    step_clk();
    check("hold_restart", 128'(busy), 128'(1));
    go = 1'b0;
    wait_done("hold_done2", 100, 1'b0);

    // Randomised runs with Go toggling while busy
    for (int r = 0; r < 8; r++) begin
      start_run(1'($urandom_range(0, 1)), 24'($urandom), 4'($urandom_range(0, 4)), 1'b0);
      wait_done("rand_done", 1500, 1'b1);
    end

    // Go mid-sweep ignored, then reset mid-sweep
    start_run(1'b0, 24'h00FF00, 4'd3, 1'b0);
    repeat (10) step_clk();
    color = 24'hFFFFFF; go = 1'b1;
    step_clk();
    go = 1'b0;
    repeat (10) step_clk();
    acc = '0;
    for (int i = 0; i < N; i++) acc |= grb[24*i +: 24];
    check("ignore_go_color", 128'(acc), 128'(24'h00FF00));
    reset = 1'b1;
    step_clk();
    check("midreset_grb",  128'(grb), 128'(0));
    check("midreset_busy", 128'(busy), 128'(0));
    reset = 1'b0;
    step_clk();

    // Single-pixel strip
    @(negedge clk);
    color_b = 24'($urandom) | 24'h000001;
    go_b = 1'b1;
    @(negedge clk);
    go_b = 1'b0;
    cb = 0; db = 0; hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (cycle_b) begin
        cb++;
        if (cb == 2) check("single_lit", 128'(grb_b), 128'(color_b));
      end
      if (done_b) begin db++; hit = 1; end
    end
    check("single_done", 128'(db), 128'(1));
    check("single_cycles", 128'(cb), 128'(4));
    repeat (2) @(negedge clk);
    check("single_dark", 128'(grb_b), 128'(0));
    check("single_idle", 128'(busy_b), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
